wb_unit: RTL

Writeback unit for the zarv core. It produces the register-file write port (rd_addr, rd_data, rd_we) from two result sources: the single-cycle ALU path and the variable-latency load-response path. It aligns and sign-extends load data, and buffers a colliding load in a one-entry hold register. It also keeps a 32-entry pending-load scoreboard that stalls decode on RAW/WAW hazards against outstanding loads.

---
 rtl/wb_unit.sv | 118 +++++++++++
 1 files changed

// File: rtl/wb_unit.sv
// rtl/wb_unit.sv - zarv writeback: ALU/load write-port arbitration, load formatting,
// one-entry collision hold buffer and pending-load hazard scoreboard.
module wb_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid_i,
  input  logic [4:0]  alu_rd_addr_i,
  input  logic [31:0] alu_rd_data_i,
  input  logic        lsu_valid_i,
  output logic        lsu_ready_o,
  input  logic [4:0]  lsu_rd_addr_i,
  input  logic [31:0] lsu_data_i,
  input  logic [2:0]  lsu_funct3_i,
  input  logic [1:0]  lsu_byte_off_i,
  input  logic        ld_issue_i,
  input  logic [4:0]  ld_issue_rd_i,
  input  logic [4:0]  dec_rs1_i,
  input  logic [4:0]  dec_rs2_i,
  input  logic [4:0]  dec_rd_i,
  output logic        stall_o,
  output logic [4:0]  rd_addr_o,
  output logic [31:0] rd_data_o,
  output logic        rd_we_o
);

  logic        r_hold_valid;
  logic        r_hold_drain;
  logic [4:0]  r_hold_addr;
  logic [31:0] r_hold_data;
  logic [31:0] r_pending;

  logic        w_lsu_fire;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_lsu_fmt;
  logic        w_wr_valid;
  logic        w_wr_is_load;
  logic [4:0]  w_wr_addr;
  logic [31:0] w_wr_data;
  logic [31:0] w_set_mask;
  logic [31:0] w_clr_mask;

  // Ready stays low through the drain cycle so it rises only after the held load is written.
  assign lsu_ready_o = !(r_hold_valid || r_hold_drain);
  assign w_lsu_fire  = lsu_valid_i && lsu_ready_o;
  assign stall_o     = r_pending[dec_rs1_i] | r_pending[dec_rs2_i] | r_pending[dec_rd_i];

  always_comb begin
    w_byte = lsu_data_i[8*lsu_byte_off_i +: 8];
    w_half = lsu_byte_off_i[1] ? lsu_data_i[31:16] : lsu_data_i[15:0];
    case (lsu_funct3_i)
      3'b000:  w_lsu_fmt = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_lsu_fmt = {{16{w_half[15]}}, w_half};
      3'b100:  w_lsu_fmt = {24'h0, w_byte};
      3'b101:  w_lsu_fmt = {16'h0, w_half};
      default: w_lsu_fmt = lsu_data_i;
    endcase
  end

  always_comb begin
    w_wr_valid   = 1'b0;
    w_wr_is_load = 1'b0;
    w_wr_addr    = rd_addr_o;
    w_wr_data    = rd_data_o;
    if (alu_valid_i) begin
      w_wr_valid = 1'b1;
      w_wr_addr  = alu_rd_addr_i;
      w_wr_data  = alu_rd_data_i;
    end else if (r_hold_valid) begin
      w_wr_valid   = 1'b1;
      w_wr_is_load = 1'b1;
      w_wr_addr    = r_hold_addr;
      w_wr_data    = r_hold_data;
    end else if (w_lsu_fire) begin
      w_wr_valid   = 1'b1;
      w_wr_is_load = 1'b1;
      w_wr_addr    = lsu_rd_addr_i;
      w_wr_data    = w_lsu_fmt;
    end
  end

  always_comb begin
    w_set_mask = 32'h0;
    w_clr_mask = 32'h0;
    if (ld_issue_i && (ld_issue_rd_i != 5'd0))
      w_set_mask = 32'h1 << ld_issue_rd_i;
    if (w_wr_is_load)
      w_clr_mask = 32'h1 << w_wr_addr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_valid <= 1'b0;
      r_hold_drain <= 1'b0;
      r_hold_addr  <= 5'd0;
      r_hold_data  <= 32'h0;
      r_pending    <= 32'h0;
      rd_we_o      <= 1'b0;
      rd_addr_o    <= 5'd0;
      rd_data_o    <= 32'h0;
    end else begin
      rd_we_o      <= w_wr_valid && (w_wr_addr != 5'd0);
      rd_addr_o    <= w_wr_addr;
      rd_data_o    <= w_wr_data;
      r_hold_drain <= !alu_valid_i && r_hold_valid;
      if (alu_valid_i && w_lsu_fire) begin
        r_hold_valid <= 1'b1;
        r_hold_addr  <= lsu_rd_addr_i;
        r_hold_data  <= w_lsu_fmt;
      end else if (!alu_valid_i && r_hold_valid) begin
        r_hold_valid <= 1'b0;
      end
      // Set wins over clear for the same index; bit 0 never gets set.
      r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
    end
  end

endmodule
